// File: rtl/tile_pkg.sv
// Shared types and constants for the tile-matching game controller.
package tile_pkg;
  localparam int         NUM_TILES          = 16;
  localparam logic [3:0] NUM_PAIRS          = 4'd8;
  localparam logic [7:0] MATCHED_COLOUR_DEF = 8'h00;

  typedef enum logic [2:0] {
    IDLE, HOLD1, READ, WAIT, COMPARE, WRITE, SHOW, WIN
  } state_t;
endpackage

// File: rtl/show_timer.sv
// Down-counter that holds a mismatched pair face-up for SHOW_CYCLES cycles.
module show_timer #(
  parameter int SHOW_CYCLES = 50000000
) (
  input  logic gameClk,
  input  logic resetn,
  input  logic load,
  input  logic dec,
  output logic done
);
  localparam int         W        = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(SHOW_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge gameClk or negedge resetn) begin
    if (!resetn)                  count <= '0;
    else if (load)                count <= LOAD_VAL;
    else if (dec && count != '0)  count <= count - 1'b1;
  end

  // Loaded with N-1 so the terminal (done) cycle is the Nth SHOW cycle.
  assign done = (count == '0);
endmodule

// File: rtl/tile_match_ctrl.sv
// Pair-matching game controller: takes two tile picks, compares their colours
// via a dual-port tile RAM, then either retires the pair or re-hides it.
module tile_match_ctrl import tile_pkg::*; #(
  parameter int         SHOW_CYCLES    = 50000000,
  parameter logic [7:0] MATCHED_COLOUR = MATCHED_COLOUR_DEF
) (
  input  logic        gameClk,
  input  logic        resetn,
  input  logic        selValid,
  input  logic [3:0]  selAddr,
  output logic [3:0]  addrA,
  output logic [3:0]  addrB,
  output logic        weA,
  output logic        weB,
  output logic [7:0]  writeA,
  output logic [7:0]  writeB,
  input  logic [7:0]  readA,
  input  logic [7:0]  readB,
  output logic [15:0] revealMask,
  output logic [15:0] matchedMask,
  output logic [3:0]  pairsFound,
  output logic        matchPulse,
  output logic        missPulse,
  output logic        busy,
  output logic        win
);
  state_t     state, nxt;
  logic [3:0] firstAddr, secondAddr;
  logic       sel_ok, accept, t_load, t_done;

  show_timer #(.SHOW_CYCLES(SHOW_CYCLES)) u_timer (
    .gameClk (gameClk),
    .resetn  (resetn),
    .load    (t_load),
    .dec     (state == SHOW),
    .done    (t_done)
  );

  assign sel_ok = selValid && !matchedMask[selAddr];

  always_ff @(posedge gameClk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt        = state;
    accept     = 1'b0;
    t_load     = 1'b0;
    weA        = 1'b0;
    weB        = 1'b0;
    matchPulse = 1'b0;
    missPulse  = 1'b0;
    busy       = 1'b1;
    win        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (sel_ok) begin
          accept = 1'b1;
          nxt    = HOLD1;
        end
      end
      HOLD1: begin
        busy = 1'b0;
        if (sel_ok && selAddr != firstAddr) begin
          accept = 1'b1;
          nxt    = READ;
        end
      end
      READ:    nxt = WAIT;
      WAIT:    nxt = COMPARE;
      COMPARE: begin
        if (readA == readB) nxt = WRITE;
        else begin
          nxt    = SHOW;
          t_load = 1'b1;
        end
      end
      WRITE: begin
        weA        = 1'b1;
        weB        = 1'b1;
        matchPulse = 1'b1;
        nxt        = (pairsFound == NUM_PAIRS - 4'd1) ? WIN : IDLE;
      end
      SHOW: begin
        if (t_done) begin
          missPulse = 1'b1;
          nxt       = IDLE;
        end
      end
      WIN:     win = 1'b1;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge gameClk or negedge resetn) begin
    if (!resetn) begin
      firstAddr   <= '0;
      secondAddr  <= '0;
      revealMask  <= '0;
      matchedMask <= '0;
      pairsFound  <= '0;
    end else begin
      if (accept) begin
        if (state == IDLE) firstAddr  <= selAddr;
        else               secondAddr <= selAddr;
        revealMask[selAddr] <= 1'b1;
      end
      if (state == WRITE) begin
        matchedMask[firstAddr]  <= 1'b1;
        matchedMask[secondAddr] <= 1'b1;
        if (pairsFound != NUM_PAIRS) pairsFound <= pairsFound + 4'd1;
      end
      // Matched tiles never reach SHOW, so their reveal bits stay set.
      if (missPulse) begin
        revealMask[firstAddr]  <= 1'b0;
        revealMask[secondAddr] <= 1'b0;
      end
    end
  end

  assign addrA  = firstAddr;
  assign addrB  = secondAddr;
  assign writeA = MATCHED_COLOUR;
  assign writeB = MATCHED_COLOUR;
endmodule

// File: tb/tb_tile_match_ctrl.sv
// Scoreboard bench for tile_match_ctrl with a behavioural dual-port tile RAM.
module tb_tile_match_ctrl;
  logic        gameClk = 0, resetn = 0, selValid = 0;
  logic [3:0]  selAddr = 0, addrA, addrB, pairsFound;
  logic        weA, weB, matchPulse, missPulse, busy, win;
  logic [7:0]  writeA, writeB, readA, readB;
  logic [15:0] revealMask, matchedMask;

  tile_match_ctrl #(.SHOW_CYCLES(4), .MATCHED_COLOUR(8'h00)) dut (
    .gameClk(gameClk), .resetn(resetn), .selValid(selValid), .selAddr(selAddr),
    .addrA(addrA), .addrB(addrB), .weA(weA), .weB(weB),
    .writeA(writeA), .writeB(writeB), .readA(readA), .readB(readB),
    .revealMask(revealMask), .matchedMask(matchedMask), .pairsFound(pairsFound),
    .matchPulse(matchPulse), .missPulse(missPulse), .busy(busy), .win(win)
  );

  always #5 gameClk = ~gameClk;

  // Board: pairs 0-3,1-4,2-7,5-12,6-10,8-11,9-13,14-15
  logic [7:0] init_b [16] = '{8'h3C, 8'hC8, 8'hA5, 8'h3C, 8'hC8, 8'h8C, 8'hF0, 8'hA5,
                              8'h11, 8'h22, 8'hF0, 8'h11, 8'h8C, 8'h22, 8'h77, 8'h77};
  logic [7:0] ram [16];

  always @(posedge gameClk) begin
    if (!resetn) ram <= init_b;
    else begin
      readA <= ram[addrA];
      readB <= ram[addrB];
      if (weA) ram[addrA] <= writeA;
      if (weB) ram[addrB] <= writeB;
    end
  end

  int cyc = 0;
  always @(posedge gameClk) cyc <= cyc + 1;

  typedef struct { bit m; logic [3:0] a, b; int cyc; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge gameClk) begin
    if (resetn && (matchPulse || missPulse || weA || weB)) begin
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result_kind", matchPulse, e.m);
        chk("result_cycle", cyc, e.cyc);
        chk("result_addrA", addrA, e.a);
        chk("result_addrB", addrB, e.b);
        if (e.m) begin
          chk("match_we", {weA, weB}, 2'b11);
          chk("match_data", {writeA, writeB}, 16'h0000);
        end else begin
          chk("miss_we", {weA, weB}, 2'b00);
          chk("miss_reveal", {revealMask[e.a], revealMask[e.b]}, 2'b11);
        end
      end
    end
  end

  task automatic sel(input logic [3:0] a, output int acc);
    @(negedge gameClk);
    selValid = 1; selAddr = a;
    @(negedge gameClk);
    selValid = 0;
    acc = cyc;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge gameClk);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge gameClk); n++; end while (busy && !win && n < 100);
    chk(nm, busy && !win, 0);
  endtask

  task automatic do_reset();
    resetn = 0;
    repeat (2) @(negedge gameClk);
    resetn = 1;
    @(negedge gameClk);
  endtask

  task automatic pair(input logic [3:0] a, input logic [3:0] b, input bit m);
    int acc;
    sel(a, acc);
    sel(b, acc);
    q.push_back('{m, a, b, m ? acc + 3 : acc + 6});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int pa[6] = '{0, 1, 2, 8, 9, 14};
    int pb[6] = '{3, 4, 7, 11, 13, 15};

    do_reset();
    chk("rst_addr", {addrA, addrB}, 8'h00);
    chk("rst_masks", {revealMask, matchedMask}, 32'h0);
    chk("rst_pairs", pairsFound, 0);
    chk("rst_flags", {weA, weB, matchPulse, missPulse, busy, win}, 6'b0);

    // Matching pair 6/10
    pair(6, 10, 1);
    wait_idle("idle_after_6_10");
    chk("pairs_1", pairsFound, 1);
    chk("matched_0440", matchedMask, 16'h0440);
    chk("reveal_0440", revealMask, 16'h0440);

    // Mismatch 0/1, with a selection landing on the SHOW->IDLE edge
    sel(0, acc);
    chk("hold1_reveal", revealMask, 16'h0441);
    chk("hold1_busy", busy, 0);
    sel(1, acc);
    q.push_back('{0, 0, 1, acc + 6});
    wait_cyc(acc + 3);
    chk("show_reveal", revealMask, 16'h0443);
    chk("show_busy", busy, 1);
    wait_cyc(acc + 6);
    selValid = 1; selAddr = 2;
    @(negedge gameClk);
    selValid = 0;
    chk("miss_pulse_once", missPulse, 0);
    chk("reveal_cleared", revealMask, 16'h0440);
    chk("edge_sel_dropped", busy, 0);

    // Drop reselect and matched tile; then match 5/12
    sel(5, acc);
    sel(5, acc);
    sel(6, acc);
    chk("drop_reveal", revealMask, 16'h0460);
    chk("drop_first", addrA, 5);
    chk("drop_still_hold", busy, 0);
    sel(12, acc);
    q.push_back('{1, 5, 12, acc + 3});
    wait_idle("idle_after_5_12");
    chk("pairs_2", pairsFound, 2);
    chk("matched_1460", matchedMask, 16'h1460);

    // Finish the board
    for (int i = 0; i < 6; i++) begin
      pair(pa[i][3:0], pb[i][3:0], 1);
      wait_idle("idle_after_pair");
    end
    chk("win_pairs", pairsFound, 8);
    chk("win_flags", {win, busy}, 2'b11);
    sel(3, acc);
    repeat (3) @(negedge gameClk);
    chk("win_hold_pairs", pairsFound, 8);
    chk("win_hold_flags", {win, busy}, 2'b11);
    chk("win_masks", {revealMask, matchedMask}, 32'hFFFF_FFFF);

    // Reset while in WRITE
    do_reset();
    chk("rst2_win", win, 0);
    sel(6, acc);
    sel(10, acc);
    q.push_back('{1, 6, 10, acc + 3});
    wait_cyc(acc + 3);
    #2 resetn = 0;
    #1;
    chk("rstw_flags", {weA, weB, matchPulse, busy, win}, 5'b0);
    chk("rstw_masks", {revealMask, matchedMask}, 32'h0);
    chk("rstw_addr_pairs", {addrA, addrB, pairsFound}, 12'h0);
    repeat (2) @(negedge gameClk);
    resetn = 1;
    repeat (10) @(negedge gameClk);
    chk("rstw_no_commit", {matchedMask, pairsFound}, 20'h0);

    // Reset while in SHOW
    sel(0, acc);
    sel(1, acc);
    wait_cyc(acc + 4);
    chk("rsts_show_reveal", revealMask, 16'h0003);
    #2 resetn = 0;
    #1;
    chk("rsts_flags", {weA, weB, missPulse, busy, win}, 5'b0);
    chk("rsts_reveal", revealMask, 16'h0);
    repeat (2) @(negedge gameClk);
    resetn = 1;
    repeat (10) @(negedge gameClk);
    chk("rsts_idle", {busy, revealMask}, 17'h0);

    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tile_match_ctrl.md
TILE_MATCH_CTRL -- requirements
Module: tile_match_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 50000000: gameClk cycles a mismatched pair stays revealed.
REQ-002 SHALL have parameter MATCHED_COLOUR, default 8'h00: colour written to both tiles of a matched pair.
REQ-003 SHALL have port gameClk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port selValid  input  1  one-cycle player selection strobe.
REQ-006 SHALL have port selAddr  input  4  tile index selected, sampled when selValid=1.
REQ-007 SHALL have port addrA  output  4  tile RAM port A address (first tile).
REQ-008 SHALL have port addrB  output  4  tile RAM port B address (second tile).
REQ-009 SHALL have port weA / weB  output  1 each  tile RAM write enables.
REQ-010 SHALL have port writeA / writeB  output  8 each  tile RAM write data.
REQ-011 SHALL have port readA / readB  input  8 each  tile RAM read data, valid one gameClk after address.
REQ-012 SHALL have port revealMask  output  16  bit i=1: tile i shown face-up.
REQ-013 SHALL have port matchedMask  output  16  bit i=1: tile i permanently matched.
REQ-014 SHALL have port pairsFound  output  4  matched pair count, 0..8.
REQ-015 SHALL have ports matchPulse / missPulse  output  1 each  one-cycle result strobes.
REQ-016 SHALL have ports busy / win  output  1 each  not accepting selections / all 8 pairs matched.

Function
REQ-017 SHALL implement FSM states IDLE, HOLD1, READ, WAIT, COMPARE, WRITE, SHOW, WIN.
REQ-018 Selection SHALL be accepted only in IDLE/HOLD1 and only when selValid=1, matchedMask[selAddr]=0, and, in HOLD1, selAddr!=firstAddr; all other selections SHALL be dropped silently.
REQ-019 IDLE + accepted selection: firstAddr<=selAddr, revealMask[selAddr]<=1, next HOLD1.
REQ-020 HOLD1 + accepted selection: secondAddr<=selAddr, revealMask[selAddr]<=1, next READ.
REQ-021 addrA SHALL equal firstAddr and addrB SHALL equal secondAddr at all times (registered outputs).
REQ-022 READ and WAIT SHALL each last exactly one cycle; COMPARE SHALL sample readA/readB.
REQ-023 COMPARE: readA==readB (full 8-bit equality) -> WRITE; otherwise -> SHOW with timer loaded to SHOW_CYCLES-1.
REQ-024 WRITE (one cycle): weA=weB=1, writeA=writeB=MATCHED_COLOUR, both matchedMask bits set, pairsFound+1, matchPulse=1; next WIN if pairsFound becomes 8, else IDLE.
REQ-025 weA/weB SHALL be 0 in every state except WRITE; writeA/writeB SHALL be MATCHED_COLOUR always.
REQ-026 SHOW: timer decrements each cycle; at 0, clear both revealMask bits, missPulse=1 for one cycle, next IDLE.
REQ-027 Matched tiles SHALL keep revealMask bit set; pairsFound SHALL saturate at 8 and never wrap.
REQ-028 WIN: win=1, busy=1, terminal until resetn asserted.
REQ-029 busy SHALL be 1 in READ, WAIT, COMPARE, WRITE, SHOW, WIN; 0 in IDLE, HOLD1.
REQ-030 selValid arriving on the same edge as a SHOW->IDLE transition SHALL be dropped.

Reset
REQ-031 resetn=0 SHALL asynchronously force state IDLE, firstAddr=secondAddr=0, revealMask=matchedMask=0, pairsFound=0, timer=0, weA=weB=0, matchPulse=missPulse=busy=win=0.
REQ-032 Reset mid-operation (any state, incl. WRITE) SHALL abort with no write issued after the asserting edge.

Structure
REQ-033 Shared package tile_pkg SHALL hold the FSM state enum, NUM_TILES=16, NUM_PAIRS=8, MATCHED_COLOUR default.
REQ-034 The mismatch delay SHALL be a sub-module show_timer (load, decrement, done flag), parameterised by SHOW_CYCLES.

Verification (SHOW_CYCLES=4; RAM model loaded with the standard 16-colour board)
REQ-035 Select 6 then 10 (both 8'hF0) -> weA=weB=1 with addrA=6, addrB=10, writeA=8'h00 exactly 3 cycles after second accept; matchPulse; pairsFound=1; matchedMask=16'h0440.
REQ-036 Select 0 then 1 (8'h3C vs 8'hC8) -> no write; revealMask=16'h0003 for 4 SHOW cycles, then 16'h0000; missPulse one cycle.
REQ-037 Select 5, reselect 5, select already-matched 6, then select 12 -> only 5 and 12 accepted; match on 8'h8C.
REQ-038 Match all 8 pairs -> pairsFound=8, win=1, busy=1; further selValid ignored.
REQ-039 Assert resetn=0 during WRITE and during SHOW -> all outputs to reset values immediately; no weA/weB pulse afterwards.
